i2c_regbank: RTL
================

# i2c_regbank

Parametrised I2C register bank that sits behind the shared `i2cslv` byte engine and replaces hand-written per-device register decoders such as the front-panel device. It decodes one 7-bit device address, owns NWR host-writable 8-bit registers and exposes NRD 8-bit read ports. It adds auto-clearing pulse registers for momentary keys, coherent multi-byte reads, and an enable gate.

## Interface
- DEV_ADDR, 7'h26: device address this bank answers to.
- NWR, 12: number of writable registers, index 0..NWR-1.
- NRD, 52: number of readable registers, index 0..NRD-1.
- PULSE_MASK, 0: NWR-bit mask; set bit = that write register is a pulse register.
- PULSE_CYC, 16: cycles a pulse-register bit stays set, at least 1.
- clk  in  1  system clock; all state on posedge.
- reset_n  in  1  asynchronous active-low reset.
- dev  in  7  current device address from `i2cslv`.
- start  in  1  one-cycle pulse, I2C START/repeated START seen.
- stop  in  1  one-cycle pulse, I2C STOP seen.
- dir  in  1  transfer direction: 0 = write, 1 = read.
- done  in  1  one-cycle pulse per completed byte (rising edge of `ack`).
- in  in  8  received byte, valid when `done`.
- ok  out  1  `dev == DEV_ADDR`; combinational.
- out  out  8  next byte to transmit.
- en  in  1  read enable; when low, reads return 8'h00.
- rd_d  in  NRD*8  read ports; register i is `rd_d[8*i+7:8*i]`, bit 7 = MSB on wire.
- wr_q  out  NWR*8  write registers, same packing.
- wr_stb  out  1  one-cycle pulse when a data byte is written.
- wr_idx  out  8  register index of the last write; valid with `wr_stb`.

## Operation
- The bank only acts while `ok` is high; `start`, `stop` and `done` are ignored otherwise.
- Write-transaction FSM (`dir == 0`), states S_DEV → S_REG → S_DATA:
  - `start` forces S_DEV.
  - In S_DEV, `done` moves to S_REG.
  - In S_REG, `done` loads `addr <= in` and moves to S_DATA.
  - In S_DATA, each `done` writes `in` to register `addr` if `addr < NWR`, pulses `wr_stb`, loads `wr_idx <= addr`, then does `addr <= addr + 1`.
  - Out-of-range writes are dropped but still increment `addr` and still pulse `wr_stb`.
- Read (`dir == 1`): each `done` loads `out` from read register `addr`, then `addr <= addr + 1`.
  - `addr >= NRD` returns 8'hFF.
  - `en == 0` returns 8'h00; this takes precedence over the 8'hFF rule.
- `stop` while `dir == 1` decrements `addr` by 1. This cancels the final prefetch, so consecutive reads resume at the first unread register.
- `addr` is 8 bits and wraps 8'hFF → 8'h00 on both increment and decrement.
- Pulse registers (PULSE_MASK bit set):
  - A written 1 bit stays set for PULSE_CYC cycles, then clears. Each register has its own down-counter.
  - A new write during an active pulse reloads the counter and ORs in the new bits.
  - Written 0 bits have no effect on an active pulse.
- Level registers hold their value until rewritten.
- Simultaneous `stop` and `done`: `done` is applied first, then the decrement.
- Simultaneous `start` and `done`: `start` wins; the state returns to S_DEV and `addr` is unchanged.

## Timing
- Reset values: `wr_q` = 0, `out` = 8'h00, `wr_stb` = 0, `wr_idx` = 0, `addr` = 0, state S_DEV, all pulse counters 0.
- Reset is asynchronous and may arrive mid-transaction; the bank then waits for the next `start`.
- Write latency: `wr_q` and `wr_stb` update on the clock edge at which `done` is sampled high.
- Read latency: `out` is valid 1 cycle after `done`. `i2cslv` samples it at the next byte's first SCL edge, which is far later.
- A pulse register bit is high for exactly PULSE_CYC cycles, counted from the edge after the write.

## Configuration
- `I2C_REGBANK_SNAPSHOT_EN` defined:
  - On the `done` that completes the device-address byte of a read, all of `rd_d` is copied into a shadow array in that cycle.
  - Every byte of that transaction is served from the shadow, so multi-byte values are coherent.
  - `out` for the first byte comes from the live `rd_d`, which is identical to the shadow in that cycle.
- Not defined: no shadow storage; each byte samples `rd_d` live on its `done`.

## Structure
- Package `i2c_pkg` holds:
  - the state encoding `S_DEV`, `S_REG`, `S_DATA`;
  - the byte constants `RD_OOR = 8'hFF` and `RD_OFF = 8'h00`.
- One sub-module, `pulse_stretch`: one 8-bit register plus a down-counter, instantiated once per PULSE_MASK bit via generate.

## Test plan
- Write at reg 3: S, dev 0x26 W, reg 0x03, 0xA5, 0x5A, P → `wr_q` reg 3 = 0xA5, reg 4 = 0x5A; two `wr_stb` pulses with `wr_idx` 3 then 4.
- Read with resume: `en` = 1, `rd_d` reg i = i. Read 3 bytes from reg 0, then a new read with no address byte → first transaction returns 0, 1, 2; second starts at 3.
- Out-of-range and wrap:
  - write at 0xFF, then 2 data bytes → `addr` wraps to 0x00 and reg 0 is written with the second byte;
  - reading at NRD returns 0xFF.
- Enable gate: `en` = 0, read reg 0 → 0x00.
- Pulse: PULSE_MASK bit 10 set, PULSE_CYC = 16, write 0x81 to reg 10 → bits 7 and 0 high for exactly 16 cycles, then 0x00.
- Snapshot (macro defined): 2-byte read with `rd_d` changed between the bytes → both bytes match the values at the device-address byte. Without the macro, the second byte reflects the new value.
- Foreign device and reset:
  - `dev` = 0x21 traffic → no state change.
  - `reset_n` low mid-write → all outputs reset; the next transaction works normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding and read-byte constants for the I2C register bank
package i2c_pkg;

  typedef enum logic [1:0] {
    S_DEV  = 2'd0,
    S_REG  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  localparam logic [7:0] RD_OOR = 8'hFF;
  localparam logic [7:0] RD_OFF = 8'h00;

  // The enable gate outranks the out-of-range rule.
  function automatic logic [7:0] read_byte(input logic enable, input logic oor,
                                           input logic [7:0] value);
    if (!enable) return RD_OFF;
    if (oor) return RD_OOR;
    return value;
  endfunction

endpackage

// File: rtl/pulse_stretch.sv
// rtl/pulse_stretch.sv - auto-clearing 8-bit register: written 1 bits hold for CYC cycles
module pulse_stretch #(
  parameter int CYC = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       we,
  input  logic [7:0] d,
  output logic [7:0] q
);

  localparam int CW = $clog2(CYC + 1);

  logic [CW-1:0] cnt;

  // A write during an active pulse merges its bits and restarts the hold time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q   <= 8'h00;
      cnt <= '0;
    end else if (we) begin
      q   <= q | d;
      cnt <= CW'(CYC);
    end else if (cnt == CW'(1)) begin
      q   <= 8'h00;
      cnt <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/i2c_regbank.sv
// rtl/i2c_regbank.sv - I2C register bank behind i2cslv; I2C_REGBANK_SNAPSHOT_EN adds a per-read shadow of rd_d
module i2c_regbank
  import i2c_pkg::*;
#(
  parameter logic [6:0]     DEV_ADDR   = 7'h26,
  parameter int             NWR        = 12,
  parameter int             NRD        = 52,
  parameter logic [NWR-1:0] PULSE_MASK = '0,
  parameter int             PULSE_CYC  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       dev,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             done,
  input  logic [7:0]       in,
  output logic             ok,
  output logic [7:0]       out,
  input  logic             en,
  input  logic [NRD*8-1:0] rd_d,
  output logic [NWR*8-1:0] wr_q,
  output logic             wr_stb,
  output logic [7:0]       wr_idx
);

  localparam logic [8:0] NRD_W = 9'(NRD);

  state_t     state;
  logic [7:0] addr;
  logic [7:0] addr_next;
  logic       go_start;
  logic       go_done;
  logic       go_stop;
  logic       wr_fire;
  logic       rd_fire;
  logic [7:0] live_byte;
  logic [7:0] src_byte;
  logic [7:0] rd_byte;

  assign ok       = (dev == DEV_ADDR);
  assign go_start = ok & start;
  assign go_done  = ok & done & ~start;
  assign go_stop  = ok & stop & ~start;
  assign wr_fire  = go_done & ~dir & (state == S_DATA);
  assign rd_fire  = go_done & dir;

  always_comb begin
    live_byte = RD_OOR;
    for (int i = 0; i < NRD; i++) begin
      if (addr == 8'(i)) live_byte = rd_d[8*i +: 8];
    end
  end

`ifdef I2C_REGBANK_SNAPSHOT_EN
  logic [NRD*8-1:0] shadow;
  logic [7:0]       shadow_byte;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow <= '0;
    end else if (rd_fire && state == S_DEV) begin
      shadow <= rd_d;
    end
  end

  always_comb begin
    shadow_byte = RD_OOR;
    for (int i = 0; i < NRD; i++) begin
      if (addr == 8'(i)) shadow_byte = shadow[8*i +: 8];
    end
  end

  // The device-address byte reads live data, which equals the shadow being captured.
  assign src_byte = (state == S_DEV) ? live_byte : shadow_byte;
`else
  assign src_byte = live_byte;
`endif

  assign rd_byte = read_byte(en, {1'b0, addr} >= NRD_W, src_byte);

  // A stop during a read undoes the last prefetch, after any same-cycle done.
  always_comb begin
    addr_next = addr;
    if (go_done) begin
      if (!dir && state == S_REG) addr_next = in;
      else if (dir || state == S_DATA) addr_next = addr + 8'd1;
    end
    if (go_stop && dir) addr_next = addr_next - 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_DEV;
      addr   <= 8'h00;
      out    <= RD_OFF;
      wr_stb <= 1'b0;
      wr_idx <= 8'h00;
    end else begin
      addr   <= addr_next;
      wr_stb <= wr_fire;
      if (wr_fire) wr_idx <= addr;
      if (rd_fire) out <= rd_byte;
      if (go_start) begin
        state <= S_DEV;
      end else if (go_done) begin
        case (state)
          S_DEV:   state <= dir ? S_DATA : S_REG;
          S_REG:   state <= S_DATA;
          default: state <= S_DATA;
        endcase
      end
    end
  end

  genvar g;
  for (g = 0; g < NWR; g++) begin : g_reg
    logic we;
    assign we = wr_fire && (addr == 8'(g));

    if (PULSE_MASK[g]) begin : g_pulse
      logic [7:0] q;
      pulse_stretch #(.CYC(PULSE_CYC)) u_pulse (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (we),
        .d       (in),
        .q       (q)
      );
      assign wr_q[8*g +: 8] = q;
    end else begin : g_level
      logic [7:0] q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) q <= 8'h00;
        else if (we) q <= in;
      end
      assign wr_q[8*g +: 8] = q;
    end
  end

endmodule
